// File: rtl/ram_arbiter.sv
// Round-robin two-port sequencer for one shared synchronous RAM; ack is same-cycle, read data returns at T+2.
// A loser simply sees ack low and holds its request; one access per cycle, up to two reads in flight.
module ram_arbiter #(
  parameter int addr_width = 16,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_wr,
  input  logic [addr_width-1:0] req0_addr,
  input  logic [data_width-1:0] req0_din,
  output logic                  req0_ack,
  output logic                  req0_rvalid,
  output logic [data_width-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_wr,
  input  logic [addr_width-1:0] req1_addr,
  input  logic [data_width-1:0] req1_din,
  output logic                  req1_ack,
  output logic                  req1_rvalid,
  output logic [data_width-1:0] req1_rdata,
  output logic                  ram_cs,
  output logic                  ram_oe,
  output logic                  ram_wr,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_q
);

  typedef struct packed {
    logic vld;
    logic port;
  } rd_stage_t;

  rd_stage_t             rd1;
  rd_stage_t             rd2;
  logic                  last;
  logic [addr_width-1:0] hold_addr;
  logic                  gnt_vld;
  logic                  gnt_port;
  logic                  gnt_wr;
  logic [addr_width-1:0] gnt_addr;
  logic [data_width-1:0] gnt_din;

  always_comb begin
    gnt_vld  = !reset && (req0_valid || req1_valid);
    gnt_port = (req0_valid && req1_valid) ? ~last : req1_valid;
    gnt_wr   = gnt_port ? req1_wr   : req0_wr;
    gnt_addr = gnt_port ? req1_addr : req0_addr;
    gnt_din  = gnt_port ? req1_din  : req0_din;
  end

  assign req0_ack = gnt_vld && !gnt_port;
  assign req1_ack = gnt_vld &&  gnt_port;

  // With no new grant, a pending read keeps cs up by re-reading hold_addr so Q stays ungated.
  always_comb begin
    ram_oe   = rd1.vld && !reset;
    ram_cs   = gnt_vld || ram_oe;
    ram_wr   = gnt_vld && gnt_wr;
    ram_addr = gnt_vld ? gnt_addr : hold_addr;
    ram_din  = gnt_vld ? gnt_din : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last       <= 1'b1;
      hold_addr  <= '0;
      rd1        <= '0;
      rd2        <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      if (gnt_vld) begin
        last <= gnt_port;
      end
      if (gnt_vld && !gnt_wr) begin
        hold_addr <= gnt_addr;
      end
      rd1.vld  <= gnt_vld && !gnt_wr;
      rd1.port <= gnt_port;
      rd2      <= rd1;
      if (rd1.vld && !rd1.port) begin
        req0_rdata <= ram_q;
      end
      if (rd1.vld && rd1.port) begin
        req1_rdata <= ram_q;
      end
    end
  end

  assign req0_rvalid = rd2.vld && !rd2.port;
  assign req1_rvalid = rd2.vld &&  rd2.port;

endmodule
